// File: rtl/mac_pkg.sv
// Shared constants and helpers for the pipelined MAC unit: mode encodings,
// the accumulator width legality check and saturation limit generators.
package mac_pkg;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_MAC = 1'b1;

   // Widest accumulator the limit helpers can describe.
   localparam int MAX_ACC_W = 256;

   function automatic bit acc_w_ok(input int data_w, input int acc_w);
      return (acc_w >= 2 * data_w) && (acc_w <= MAX_ACC_W);
   endfunction

   function automatic logic [MAX_ACC_W-1:0] sat_pos_limit(input int acc_w);
      logic [MAX_ACC_W-1:0] one_v;
      one_v = MAX_ACC_W'(1);
      return (one_v << (acc_w - 1)) - one_v;
   endfunction

   function automatic logic [MAX_ACC_W-1:0] sat_neg_limit(input int acc_w);
      logic [MAX_ACC_W-1:0] one_v;
      one_v = MAX_ACC_W'(1);
      return one_v << (acc_w - 1);
   endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Signed ACC_W adder reporting two's-complement overflow; when MAC_SATURATE_EN
// is defined the result clamps to the signed limits instead of wrapping.
module mac_sat_add
   import mac_pkg::*;
#(
   parameter int ACC_W = 64
) (
   input  logic signed [ACC_W-1:0] x,
   input  logic signed [ACC_W-1:0] y,
   output logic signed [ACC_W-1:0] sum,
   output logic                    ovf
);

   logic signed [ACC_W-1:0] raw;

   assign raw = x + y;
   assign ovf = (x[ACC_W-1] == y[ACC_W-1]) && (raw[ACC_W-1] != x[ACC_W-1]);

`ifdef MAC_SATURATE_EN
   localparam logic [ACC_W-1:0] SAT_POS = ACC_W'(sat_pos_limit(ACC_W));
   localparam logic [ACC_W-1:0] SAT_NEG = ACC_W'(sat_neg_limit(ACC_W));

   assign sum = !ovf ? raw : (x[ACC_W-1] ? SAT_NEG : SAT_POS);
`else
   assign sum = raw;
`endif

endmodule

// File: rtl/mac_unit_pipe.sv
// Two-stage pipelined signed MUL/MAC unit with valid/ready handshakes; groups of
// MAC terms end on in_last. Define MAC_SATURATE_EN for saturating accumulation.
module mac_unit_pipe
   import mac_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              mul_mac_signal,
   input  logic              in_last,
   output logic [ACC_W-1:0]  o,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sat,
   output logic [CNT_W-1:0]  term_cnt
);

   generate
      if (!acc_w_ok(DATA_W, ACC_W)) begin : g_bad_acc_w
         $error("mac_unit_pipe: ACC_W must be >= 2*DATA_W (and <= MAX_ACC_W)");
      end
   endgenerate

`ifdef MAC_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic signed [2*DATA_W-1:0] p_q, p_d;
   logic                       p_mode_q, p_mode_d;
   logic                       p_last_q, p_last_d;
   logic                       p_valid_q, p_valid_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic                       first_q, first_d;
   logic [CNT_W-1:0]           term_cnt_q, term_cnt_d;
   logic [ACC_W-1:0]           o_q, o_d;
   logic                       out_valid_q, out_valid_d;
   logic                       out_sat_q, out_sat_d;
   logic                       sat_flag_q, sat_flag_d;

   logic                       advance;
   logic                       accept;
   logic signed [ACC_W-1:0]    p_ext;
   logic signed [ACC_W-1:0]    base;
   logic signed [ACC_W-1:0]    sum;
   logic                       add_ovf;

   assign advance = !out_valid_q || out_ready;
   assign accept  = in_valid && advance;
   assign p_ext   = ACC_W'(p_q);
   assign base    = first_q ? '0 : acc_q;

   mac_sat_add #(.ACC_W(ACC_W)) u_add (
      .x   (base),
      .y   (p_ext),
      .sum (sum),
      .ovf (add_ovf)
   );

   // MUL beats bypass the accumulator so they can interleave inside an open group.
   always_comb begin
      p_d         = p_q;
      p_mode_d    = p_mode_q;
      p_last_d    = p_last_q;
      p_valid_d   = p_valid_q;
      acc_d       = acc_q;
      first_d     = first_q;
      term_cnt_d  = term_cnt_q;
      o_d         = o_q;
      out_valid_d = out_valid_q;
      out_sat_d   = out_sat_q;
      sat_flag_d  = sat_flag_q;
      if (advance) begin
         p_valid_d = accept;
         if (accept) begin
            p_d      = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
            p_mode_d = mul_mac_signal;
            p_last_d = in_last;
         end
         out_valid_d = 1'b0;
         if (p_valid_q) begin
            if (p_mode_q == MODE_MUL) begin
               o_d         = p_ext;
               out_valid_d = 1'b1;
               out_sat_d   = 1'b0;
            end else if (p_last_q) begin
               o_d         = sum;
               out_valid_d = 1'b1;
               out_sat_d   = SAT_EN && (sat_flag_q || add_ovf);
               acc_d       = '0;
               first_d     = 1'b1;
               term_cnt_d  = '0;
               sat_flag_d  = 1'b0;
            end else begin
               acc_d      = sum;
               first_d    = 1'b0;
               term_cnt_d = term_cnt_q + CNT_W'(1);
               sat_flag_d = SAT_EN && (sat_flag_q || add_ovf);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q         <= '0;
         p_mode_q    <= MODE_MUL;
         p_last_q    <= 1'b0;
         p_valid_q   <= 1'b0;
         acc_q       <= '0;
         first_q     <= 1'b1;
         term_cnt_q  <= '0;
         o_q         <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         sat_flag_q  <= 1'b0;
      end else begin
         p_q         <= p_d;
         p_mode_q    <= p_mode_d;
         p_last_q    <= p_last_d;
         p_valid_q   <= p_valid_d;
         acc_q       <= acc_d;
         first_q     <= first_d;
         term_cnt_q  <= term_cnt_d;
         o_q         <= o_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
         sat_flag_q  <= sat_flag_d;
      end
   end

   assign in_ready  = advance;
   assign o         = o_q;
   assign out_valid = out_valid_q;
   assign out_sat   = out_sat_q;
   assign term_cnt  = term_cnt_q;

endmodule

// File: tb/tb_mac_unit_pipe.sv
// Directed, table-driven bench for mac_unit_pipe: a 32/64-bit instance for the
// streaming, stall and reset cases, plus an 8/16-bit instance for saturation.
module tb_mac_unit_pipe;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, mode, last, out_valid, out_ready, out_sat;
   logic [31:0] a, b;
   logic [63:0] o;
   logic [15:0] term_cnt;

   logic        in_valid8, in_ready8, mode8, last8, out_valid8, out_ready8, out_sat8;
   logic [7:0]  a8, b8;
   logic [15:0] o8;
   logic [15:0] term_cnt8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_unit_pipe #(.DATA_W(32), .ACC_W(64), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .a              (a),
      .b              (b),
      .mul_mac_signal (mode),
      .in_last        (last),
      .o              (o),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sat        (out_sat),
      .term_cnt       (term_cnt)
   );

   mac_unit_pipe #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) dut8 (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid8),
      .in_ready       (in_ready8),
      .a              (a8),
      .b              (b8),
      .mul_mac_signal (mode8),
      .in_last        (last8),
      .o              (o8),
      .out_valid      (out_valid8),
      .out_ready      (out_ready8),
      .out_sat        (out_sat8),
      .term_cnt       (term_cnt8)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        mode;
      logic        last;
      logic        exp_valid;
      logic [63:0] exp_o;
      logic        exp_sat;
      logic [15:0] exp_cnt;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] av, input logic [31:0] bv,
                                input logic md, input logic lst);
      in_valid = v;
      a        = av;
      b        = bv;
      mode     = md;
      last     = lst;
   endtask

   task automatic applyStimulus8(input logic v, input logic [7:0] av, input logic [7:0] bv,
                                 input logic md, input logic lst);
      in_valid8 = v;
      a8        = av;
      b8        = bv;
      mode8     = md;
      last8     = lst;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] av, input logic [31:0] bv, input logic md,
                               input logic lst, input logic ev, input logic [63:0] eo,
                               input logic es, input logic [15:0] ec);
      vec_t r;
      r.a = av; r.b = bv; r.mode = md; r.last = lst;
      r.exp_valid = ev; r.exp_o = eo; r.exp_sat = es; r.exp_cnt = ec;
      return r;
   endfunction

   initial begin
      vecs[0]  = mk(32'hFFFFFFF6, 32'd1, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF6, 1'b0, 16'd0);
      vecs[1]  = mk(32'hFFFFFFF6, 32'd1, 1'b1, 1'b0, 1'b0, 64'd0,                1'b0, 16'd1);
      vecs[2]  = mk(32'd1,        32'd8, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 16'd0);
      vecs[3]  = mk(32'd3,        32'd4, 1'b1, 1'b1, 1'b1, 64'd12,               1'b0, 16'd0);
      vecs[4]  = mk(32'd2,        32'd3, 1'b1, 1'b0, 1'b0, 64'd0,                1'b0, 16'd1);
      vecs[5]  = mk(32'd5,        32'd5, 1'b0, 1'b0, 1'b1, 64'd25,               1'b0, 16'd1);
      vecs[6]  = mk(32'd1,        32'd1, 1'b1, 1'b1, 1'b1, 64'd7,                1'b0, 16'd0);
      vecs[7]  = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 64'h3FFFFFFF00000001, 1'b0, 16'd0);
      vecs[8]  = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 64'h4000000000000000, 1'b0, 16'd0);
      vecs[9]  = mk(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 64'hC000000080000000, 1'b0, 16'd0);
      vecs[10] = mk(32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 16'd1);
      vecs[11] = mk(32'hFFFFFFFB, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 16'd2);
      vecs[12] = mk(32'd0,        32'd9, 1'b1, 1'b1, 1'b1, 64'd4, 1'b0, 16'd0);
      vecs[13] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 16'd1);
      vecs[14] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 16'd2);
      vecs[15] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 16'd3);
`ifdef MAC_SATURATE_EN
      vecs[16] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 16'd0);
`else
      vecs[16] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFC00000004, 1'b0, 16'd0);
`endif

      rst = 1'b1;
      out_ready = 1'b1;
      out_ready8 = 1'b1;
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_o", o, 64'd0);
      checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset_out_sat", {63'd0, out_sat}, 64'd0);
      checkOutput("reset_term_cnt", {48'd0, term_cnt}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("reset8_out_valid", {63'd0, out_valid8}, 64'd0);

      // Streaming table: the result of vector i is visible two cycles after it is driven.
      for (int i = 0; i < NVEC + 2; i++) begin
         tick();
         if (i < NVEC)
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].last);
         else
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         @(negedge clk);
         if (i >= 2) begin
            checkOutput($sformatf("vec%0d_out_valid", i - 2), {63'd0, out_valid},
                        {63'd0, vecs[i-2].exp_valid});
            checkOutput($sformatf("vec%0d_term_cnt", i - 2), {48'd0, term_cnt},
                        {48'd0, vecs[i-2].exp_cnt});
            if (vecs[i-2].exp_valid) begin
               checkOutput($sformatf("vec%0d_o", i - 2), o, vecs[i-2].exp_o);
               checkOutput($sformatf("vec%0d_out_sat", i - 2), {63'd0, out_sat},
                           {63'd0, vecs[i-2].exp_sat});
            end
         end
      end

      // Backpressure: MAC 9*1 open, MUL 4*5 emitted then stalled, MAC 6*7 held in P.
      tick();
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'd9, 32'd1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 32'd4, 32'd5, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'd6, 32'd7, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 32'd1, 32'd2, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("stall%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
         checkOutput($sformatf("stall%0d_out_valid", k), {63'd0, out_valid}, 64'd1);
         checkOutput($sformatf("stall%0d_o", k), o, 64'd20);
         checkOutput($sformatf("stall%0d_term_cnt", k), {48'd0, term_cnt}, 64'd1);
         if (k < 5) tick();
      end
      out_ready = 1'b1;
      tick();
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("release_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("release_term_cnt", {48'd0, term_cnt}, 64'd2);
      tick();
      @(negedge clk);
      checkOutput("release_result_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("release_result_o", o, 64'd53);
      checkOutput("release_result_cnt", {48'd0, term_cnt}, 64'd0);
      tick();
      @(negedge clk);
      checkOutput("release_no_dup", {63'd0, out_valid}, 64'd0);

      // Reset in the middle of an open group discards the partial sum.
      applyStimulus(1'b1, 32'd100, 32'd100, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      @(negedge clk);
      checkOutput("midgrp_term_cnt", {48'd0, term_cnt}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_term_cnt", {48'd0, term_cnt}, 64'd0);
      checkOutput("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      applyStimulus(1'b1, 32'd1, 32'd1, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("post_rst_wait_valid", {63'd0, out_valid}, 64'd0);
      tick();
      @(negedge clk);
      checkOutput("post_rst_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("post_rst_o", o, 64'd1);

      // Narrow instance: MUL boundary, then three 127*127 MAC terms.
      tick();
      applyStimulus8(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
      tick();
      applyStimulus8(1'b1, 8'd127, 8'd127, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("n8_idle_valid", {63'd0, out_valid8}, 64'd0);
      tick();
      applyStimulus8(1'b1, 8'd127, 8'd127, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("n8_mul_valid", {63'd0, out_valid8}, 64'd1);
      checkOutput("n8_mul_o", {48'd0, o8}, 64'h4000);
      tick();
      applyStimulus8(1'b1, 8'd127, 8'd127, 1'b1, 1'b1);
      tick();
      applyStimulus8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("n8_open_valid", {63'd0, out_valid8}, 64'd0);
      checkOutput("n8_open_cnt", {48'd0, term_cnt8}, 64'd2);
      tick();
      @(negedge clk);
      checkOutput("n8_mac_valid", {63'd0, out_valid8}, 64'd1);
`ifdef MAC_SATURATE_EN
      checkOutput("n8_mac_o", {48'd0, o8}, 64'h7FFF);
      checkOutput("n8_mac_sat", {63'd0, out_sat8}, 64'd1);
`else
      checkOutput("n8_mac_o", {48'd0, o8}, 64'hBD03);
      checkOutput("n8_mac_sat", {63'd0, out_sat8}, 64'd0);
`endif
      checkOutput("n8_mac_cnt", {48'd0, term_cnt8}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_unit_pipe.md
Name: mac_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle MAC unit.
- Signed DATA_W x DATA_W multiply, with per-term MUL or MAC mode.
- Accumulation groups are delimited by in_last; the block emits one registered result per group.
- Valid/ready handshake on both sides, so it can sit between the DLX operand path and a writeback FIFO.

Parameters:
- DATA_W, 32, operand width; operands are treated as two's-complement signed.
- ACC_W, 64, accumulator and result width; must satisfy ACC_W >= 2*DATA_W (elaboration error otherwise).
- CNT_W, 16, width of the term counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  DATA_W  signed operand A.
- b  in  DATA_W  signed operand B.
- mul_mac_signal  in  1  per-beat mode: 1 = MAC (accumulate), 0 = MUL (emit product alone).
- in_last  in  1  final MAC term of the current group; ignored in MUL mode.
- o  out  ACC_W  signed result.
- out_valid  out  1  o is valid.
- out_ready  in  1  downstream accepts o.
- out_sat  out  1  the group result was saturated (see Optional Feature).
- term_cnt  out  CNT_W  MAC terms accepted into the current open group.

Behaviour:

Reset (rst=1 at a clock edge), effective immediately including mid-group or mid-stall:
- o=0, out_valid=0, out_sat=0.
- Accumulator=0, term_cnt=0, first=1.
- All stage valid bits=0.
- in_ready is combinational and reads 1 in the cycle after reset.

Pipeline enable and handshake:
- advance = !out_valid || out_ready.
- in_ready = advance.
- Beat accepted when in_valid && in_ready.
- When advance=0, every pipeline register holds, including the accumulator and term_cnt.

Stage P:
- On accept, p_q <= $signed(a)*$signed(b), full 2*DATA_W bits.
- p_mode, p_last and p_valid are captured in the same edge.
- p_valid <= 0 when advancing without an accepted beat.

Stage A (on advance with p_valid=1):
- MUL beat: o <= sign-extend(p_q) to ACC_W; out_valid <= 1; out_sat <= 0. Accumulator, first and term_cnt are untouched, so a MUL beat may interleave inside an open MAC group.
- MAC beat, base: base = first ? 0 : acc; sum = base + sign-extend(p_q).
- MAC beat, non-last: acc <= sum; first <= 0.
- MAC beat, last: o <= sum; out_valid <= 1; acc <= 0; first <= 1.
- term_cnt: increments on MAC beats when p_valid is consumed; wraps at 2^CNT_W; cleared to 0 on the last beat.

Output stage:
- On advance with no result produced, out_valid <= 0.
- o and out_sat hold while out_valid && !out_ready.

Latency and throughput:
- A beat accepted at edge t produces out_valid=1 after edge t+1, i.e. 2 cycles.
- Throughput is 1 beat/cycle when out_ready=1.
- Back-to-back groups need no bubble.

Arithmetic:
- Wrap modulo 2^ACC_W unless saturation is enabled.
- The product never overflows, since ACC_W >= 2*DATA_W.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: each MAC addition uses signed-overflow detection (operands have equal signs and the sum's sign differs). On overflow, the result clamps to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)), and a sticky per-group sat flag is set. out_sat <= sticky flag when the group result is emitted. The flag clears on emit and on reset.
- Undefined: the sum wraps and out_sat is tied to 0.

Decomposition:
- Package mac_pkg holds:
  - MODE_MUL=1'b0 and MODE_MAC=1'b1;
  - the ACC_W >= 2*DATA_W check;
  - saturation limit constants as functions of ACC_W.
- One natural sub-module, mac_sat_add: ACC_W signed adder with an ovf output and, under MAC_SATURATE_EN, a clamped result.

Test Plan:
1. MUL beat a=32'hFFFFFFF6 (-10), b=1, mul_mac_signal=0, out_ready=1 -> 2 cycles later out_valid=1, o=-10 (64'hFFFFFFFFFFFFFFF6), term_cnt stays 0.
2. MAC group (-10*1), (1*8, in_last=1) on consecutive cycles -> single out_valid pulse, o=-2; term_cnt reads 1 then 0; then a group (3*4, last) -> o=12, proving the accumulator cleared.
3. Backpressure: out_ready=0 while out_valid=1 -> in_ready=0; o, term_cnt and the accumulator are frozen for 5 cycles. Release -> the next group result follows with no lost or duplicated beats.
4. Interleave: MAC 2*3, MUL 5*5, MAC 1*1 last -> outputs 25 then 7, in order.
5. Reset mid-group: after MAC 100*100, assert rst for 1 cycle, then MAC 1*1 last -> o=1, out_valid held 0 during and after reset until the new result.
6. DATA_W=8, ACC_W=16: three MAC beats 127*127, last on the third -> with MAC_SATURATE_EN o=32767, out_sat=1; without it o=-17149, out_sat=0.
